// File: rtl/dbus_arbiter_rr_if.sv
// DBus bundle between the round-robin arbiter and its DTMs / Debug Module.
// slave: the arbiter's view; master: the DTMs and DM that surround it.

interface dbus_arbiter_rr_if #(
  parameter int unsigned NUM_PORTS     = 2,
  parameter int unsigned DBUS_REQ_BITS = 41,
  parameter int unsigned DBUS_RSP_BITS = 36
);
  logic [NUM_PORTS-1:0]               dtm_req_req;
  logic [NUM_PORTS-1:0]               dtm_req_ack;
  logic [NUM_PORTS*DBUS_REQ_BITS-1:0] dtm_req_bits;
  logic [NUM_PORTS-1:0]               dtm_rsp_req;
  logic [NUM_PORTS-1:0]               dtm_rsp_ack;
  logic [NUM_PORTS*DBUS_RSP_BITS-1:0] dtm_rsp_bits;
  logic                               dm_req_req;
  logic                               dm_req_ack;
  logic [DBUS_REQ_BITS-1:0]           dm_req_bits;
  logic                               dm_rsp_req;
  logic                               dm_rsp_ack;
  logic [DBUS_RSP_BITS-1:0]           dm_rsp_bits;

  modport slave (
    input  dtm_req_req, dtm_req_bits, dtm_rsp_ack, dm_req_ack, dm_rsp_req, dm_rsp_bits,
    output dtm_req_ack, dtm_rsp_req, dtm_rsp_bits, dm_req_req, dm_req_bits, dm_rsp_ack
  );

  modport master (
    output dtm_req_req, dtm_req_bits, dtm_rsp_ack, dm_req_ack, dm_rsp_req, dm_rsp_bits,
    input  dtm_req_ack, dtm_rsp_req, dtm_rsp_bits, dm_req_req, dm_req_bits, dm_rsp_ack
  );
endinterface

// File: rtl/dbus_arbiter_rr.sv
// Round-robin arbiter multiplexing NUM_PORTS DTMs onto one Debug Module over four-phase
// req/ack DBus handshakes; every asynchronous handshake input is synchronized first.

module dbus_arbiter_rr #(
  parameter int unsigned  NUM_PORTS     = 2,
  parameter int unsigned  DBUS_REQ_BITS = 41,
  parameter int unsigned  DBUS_RSP_BITS = 36,
  parameter int unsigned  SYNC_STAGES   = 2,
  localparam int unsigned PORT_W        = $clog2(NUM_PORTS)
) (
  input  logic                clk,
  input  logic                rst,
  dbus_arbiter_rr_if.slave    bus,
  output logic [PORT_W-1:0]   grant_id,
  output logic                busy
);

  typedef enum logic [2:0] {
    StIdle, StReq, StReqRel, StRspWait, StRspDmRel, StRspFwd, StRspRel
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0][NUM_PORTS-1:0] req_sync_q, rsp_ack_sync_q;
  logic [SYNC_STAGES-1:0]                dm_req_ack_sync_q, dm_rsp_req_sync_q;
  logic [NUM_PORTS-1:0]                  req_s, rsp_ack_s;
  logic                                  dm_req_ack_s, dm_rsp_req_s;

  logic [PORT_W-1:0]                     rr_ptr_q, rr_ptr_d;
  logic [PORT_W-1:0]                     grant_q, grant_d;
  logic [NUM_PORTS-1:0]                  req_ack_q, req_ack_d;
  logic [NUM_PORTS-1:0]                  rsp_req_q, rsp_req_d;
  logic [NUM_PORTS*DBUS_RSP_BITS-1:0]    rsp_bits_q, rsp_bits_d;
  logic                                  dm_req_req_q, dm_req_req_d;
  logic [DBUS_REQ_BITS-1:0]              dm_req_bits_q, dm_req_bits_d;
  logic                                  dm_rsp_ack_q, dm_rsp_ack_d;

  logic [NUM_PORTS-1:0]                  elig;
  logic                                  pick_vld;
  logic [PORT_W-1:0]                     pick;
  int unsigned                           cand;

  assign req_s        = req_sync_q[SYNC_STAGES-1];
  assign rsp_ack_s    = rsp_ack_sync_q[SYNC_STAGES-1];
  assign dm_req_ack_s = dm_req_ack_sync_q[SYNC_STAGES-1];
  assign dm_rsp_req_s = dm_rsp_req_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      req_sync_q        <= '0;
      rsp_ack_sync_q    <= '0;
      dm_req_ack_sync_q <= '0;
      dm_rsp_req_sync_q <= '0;
    end else begin
      req_sync_q        <= {req_sync_q[SYNC_STAGES-2:0], bus.dtm_req_req};
      rsp_ack_sync_q    <= {rsp_ack_sync_q[SYNC_STAGES-2:0], bus.dtm_rsp_ack};
      dm_req_ack_sync_q <= {dm_req_ack_sync_q[SYNC_STAGES-2:0], bus.dm_req_ack};
      dm_rsp_req_sync_q <= {dm_rsp_req_sync_q[SYNC_STAGES-2:0], bus.dm_rsp_req};
    end
  end

  // A port already acked is ineligible until it drops its request.
  always_comb begin
    elig     = req_s & ~req_ack_q;
    pick_vld = 1'b0;
    pick     = '0;
    cand     = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!pick_vld && elig[PORT_W'(cand)]) begin
        pick_vld = 1'b1;
        pick     = PORT_W'(cand);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    rsp_req_d     = rsp_req_q;
    rsp_bits_d    = rsp_bits_q;
    dm_req_req_d  = dm_req_req_q;
    dm_req_bits_d = dm_req_bits_q;
    dm_rsp_ack_d  = dm_rsp_ack_q;
    // Acks drop as soon as the synchronized request does, independent of the FSM.
    req_ack_d     = req_ack_q & req_s;
    case (state_q)
      StIdle: begin
        if (pick_vld) begin
          grant_d         = pick;
          dm_req_bits_d   = bus.dtm_req_bits[32'(pick)*DBUS_REQ_BITS +: DBUS_REQ_BITS];
          req_ack_d[pick] = 1'b1;
          dm_req_req_d    = 1'b1;
          state_d         = StReq;
        end
      end
      StReq: begin
        if (dm_req_ack_s) begin
          dm_req_req_d = 1'b0;
          state_d      = StReqRel;
        end
      end
      StReqRel: begin
        if (!dm_req_ack_s) state_d = StRspWait;
      end
      StRspWait: begin
        if (dm_rsp_req_s) begin
          rsp_bits_d[32'(grant_q)*DBUS_RSP_BITS +: DBUS_RSP_BITS] = bus.dm_rsp_bits;
          dm_rsp_ack_d = 1'b1;
          state_d      = StRspDmRel;
        end
      end
      StRspDmRel: begin
        if (!dm_rsp_req_s) begin
          dm_rsp_ack_d       = 1'b0;
          rsp_req_d[grant_q] = 1'b1;
          state_d            = StRspFwd;
        end
      end
      StRspFwd: begin
        if (rsp_ack_s[grant_q]) begin
          rsp_req_d[grant_q] = 1'b0;
          state_d            = StRspRel;
        end
      end
      StRspRel: begin
        if (!rsp_ack_s[grant_q]) begin
          rr_ptr_d = (32'(grant_q) == NUM_PORTS - 1) ? '0 : grant_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      req_ack_q     <= '0;
      rsp_req_q     <= '0;
      rsp_bits_q    <= '0;
      dm_req_req_q  <= 1'b0;
      dm_req_bits_q <= '0;
      dm_rsp_ack_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      req_ack_q     <= req_ack_d;
      rsp_req_q     <= rsp_req_d;
      rsp_bits_q    <= rsp_bits_d;
      dm_req_req_q  <= dm_req_req_d;
      dm_req_bits_q <= dm_req_bits_d;
      dm_rsp_ack_q  <= dm_rsp_ack_d;
    end
  end

  assign bus.dtm_req_ack  = req_ack_q;
  assign bus.dtm_rsp_req  = rsp_req_q;
  assign bus.dtm_rsp_bits = rsp_bits_q;
  assign bus.dm_req_req   = dm_req_req_q;
  assign bus.dm_req_bits  = dm_req_bits_q;
  assign bus.dm_rsp_ack   = dm_rsp_ack_q;
  assign grant_id         = grant_q;
  assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_dbus_arbiter_rr.sv
// Self-checking bench for dbus_arbiter_rr: DTM and DM agents driven from one process, a
// hand-written grant-order table, directed corner cases and a randomized round-robin model.

module tb_dbus_arbiter_rr;
  localparam int unsigned NP = 4;
  localparam int unsigned RB = 41;
  localparam int unsigned SB = 36;
  localparam int unsigned SS = 2;

  localparam int SelDmReq    = 0;
  localparam int SelDmRspAck = 1;
  localparam int SelDtmRsp   = 2;
  localparam int SelBusy     = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant_id;
  logic       busy;

  always #5 clk = ~clk;

  dbus_arbiter_rr_if #(.NUM_PORTS(NP), .DBUS_REQ_BITS(RB), .DBUS_RSP_BITS(SB)) bus ();

  dbus_arbiter_rr #(
    .NUM_PORTS(NP), .DBUS_REQ_BITS(RB), .DBUS_RSP_BITS(SB), .SYNC_STAGES(SS)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_id(grant_id), .busy(busy)
  );

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [RB-1:0] req_data [NP];
  logic [SB-1:0] rsp_model [NP];
  logic [RB-1:0] granted_bits;
  int            m_ptr;
  int            n_grants;
  logic [NP-1:0] pend, late;
  logic [1:0]    g_m;

  typedef struct packed {
    logic [3:0]  mask;  // ports raising a request together
    logic [15:0] ord;   // expected grant order, first grant in the top nibble
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel, input logic [1:0] p);
    case (sel)
      SelDmReq:    return bus.dm_req_req;
      SelDmRspAck: return bus.dm_rsp_ack;
      SelDtmRsp:   return bus.dtm_rsp_req[p];
      default:     return busy;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic [1:0] p, input logic val, input string name);
    int n = 0;
    while (sig(sel, p) !== val && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sig(sel, p) !== val) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout %s: got %b, want %b", name, sig(sel, p), val);
    end
  endtask

  function automatic logic [RB-1:0] rnd_req();
    return RB'({$urandom(), $urandom()});
  endfunction

  function automatic logic [SB-1:0] rnd_rsp();
    return SB'({$urandom(), $urandom()});
  endfunction

  function automatic logic [NP*SB-1:0] model_vec();
    logic [NP*SB-1:0] v;
    for (int p = 0; p < NP; p++) v[p*SB +: SB] = rsp_model[p];
    return v;
  endfunction

  // First pending port at or after the model pointer, wrapping.
  function automatic logic [1:0] model_pick(input logic [NP-1:0] pnd);
    for (int i = 0; i < NP; i++) begin
      int c = (m_ptr + i) % NP;
      if (pnd[c[1:0]]) return c[1:0];
    end
    return 2'd0;
  endfunction

  task automatic raise(input logic [1:0] p, input logic [RB-1:0] d);
    req_data[p]                = d;
    bus.dtm_req_bits[p*RB +: RB] = d;
    bus.dtm_req_req[p]         = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " dtm_req_ack"}, bus.dtm_req_ack, '0);
    chk({tag, " dtm_rsp_req"}, bus.dtm_rsp_req, '0);
    chk({tag, " dtm_rsp_bits"}, bus.dtm_rsp_bits, '0);
    chk({tag, " dm_req_req"}, bus.dm_req_req, '0);
    chk({tag, " dm_req_bits"}, bus.dm_req_bits, '0);
    chk({tag, " dm_rsp_ack"}, bus.dm_rsp_ack, '0);
    chk({tag, " grant_id"}, grant_id, '0);
    chk({tag, " busy"}, busy, '0);
  endtask

  task automatic req_phase(input logic [1:0] g, input bit hold);
    wait_sig(SelDmReq, g, 1'b1, "dm_req_req rise");
    chk("grant_id", grant_id, g);
    chk("dm_req_bits", bus.dm_req_bits, req_data[g]);
    chk("dtm_req_ack", bus.dtm_req_ack[g], 1'b1);
    granted_bits = req_data[g];
    if (!hold) bus.dtm_req_req[g] = 1'b0;
    bus.dtm_req_bits[g*RB +: RB] = rnd_req();
    bus.dm_req_ack = 1'b1;
    wait_sig(SelDmReq, g, 1'b0, "dm_req_req fall");
    bus.dm_req_ack = 1'b0;
  endtask

  task automatic rsp_phase(input logic [1:0] g, input logic [SB-1:0] rsp, input logic [NP-1:0] lt);
    logic [NP-1:0] onehot;
    repeat (4) @(negedge clk);
    for (int p = 0; p < NP; p++) if (lt[p[1:0]]) raise(p[1:0], rnd_req());
    repeat (4) @(negedge clk);
    chk("in-flight hold", {busy, bus.dm_req_req, grant_id}, {1'b1, 1'b0, g});
    chk("dm_req_bits stable", bus.dm_req_bits, granted_bits);
    bus.dm_rsp_bits = rsp;
    bus.dm_rsp_req  = 1'b1;
    wait_sig(SelDmRspAck, g, 1'b1, "dm_rsp_ack rise");
    bus.dm_rsp_req  = 1'b0;
    bus.dm_rsp_bits = rnd_rsp();
    wait_sig(SelDmRspAck, g, 1'b0, "dm_rsp_ack fall");
    rsp_model[g] = rsp;
    wait_sig(SelDtmRsp, g, 1'b1, "dtm_rsp_req rise");
    onehot    = '0;
    onehot[g] = 1'b1;
    chk("dtm_rsp_req", bus.dtm_rsp_req, onehot);
    chk("dtm_rsp_bits", bus.dtm_rsp_bits, model_vec());
  endtask

  task automatic fwd_phase(input logic [1:0] g);
    bus.dtm_rsp_ack[g] = 1'b1;
    wait_sig(SelDtmRsp, g, 1'b0, "dtm_rsp_req fall");
    bus.dtm_rsp_ack[g] = 1'b0;
    wait_sig(SelBusy, g, 1'b0, "return to idle");
    m_ptr = (int'(g) + 1) % NP;
  endtask

  task automatic run_txn(input logic [1:0] g, input logic [SB-1:0] rsp, input bit hold,
                         input logic [NP-1:0] lt);
    req_phase(g, hold);
    rsp_phase(g, rsp, lt);
    fwd_phase(g);
  endtask

  task automatic idle_watch(input int n, input string name);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.dm_req_req) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = {4'b1111, 16'h2301};
    vecs[1] = {4'b0011, 16'h0100};
    vecs[2] = {4'b1000, 16'h3000};
    vecs[3] = {4'b1111, 16'h0123};
    vecs[4] = {4'b0110, 16'h1200};
    vecs[5] = {4'b1001, 16'h3000};
    vecs[6] = {4'b1101, 16'h2300};
    vecs[7] = {4'b0101, 16'h2000};

    rst              = 1'b1;
    bus.dtm_req_req  = '0;
    bus.dtm_req_bits = '0;
    bus.dtm_rsp_ack  = '0;
    bus.dm_req_ack   = 1'b0;
    bus.dm_rsp_req   = 1'b0;
    bus.dm_rsp_bits  = '0;
    for (int p = 0; p < NP; p++) begin
      req_data[p]  = '0;
      rsp_model[p] = '0;
    end
    m_ptr = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Latency to the DM and a single round trip on port 1.
    raise(2'd1, 41'h1_2345_6789A);
    for (int e = 1; e <= SS + 1; e++) begin
      @(negedge clk);
      chk($sformatf("dm_req_req after %0d edges", e), bus.dm_req_req, (e == SS + 1));
      chk($sformatf("dtm_req_ack[1] after %0d edges", e), bus.dtm_req_ack[1], (e == SS + 1));
    end
    run_txn(2'd1, 36'h9_8765_4321, 1'b0, '0);
    chk("slice 0 untouched", bus.dtm_rsp_bits[SB-1:0], '0);
    chk("slice 1 response", bus.dtm_rsp_bits[SB +: SB], 36'h9_8765_4321);

    // Grant order for simultaneous requests; pointer starts at 2 here.
    for (int v = 0; v < 8; v++) begin
      n_grants = $countones(vecs[v].mask);
      for (int p = 0; p < NP; p++) if (vecs[v].mask[p[1:0]]) raise(p[1:0], rnd_req());
      for (int k = 0; k < n_grants; k++) begin
        g_m = vecs[v].ord[(3-k)*4 +: 2];
        run_txn(g_m, rnd_rsp(), 1'b0, '0);
      end
    end

    // Request held high after its ack must not be granted again.
    raise(2'd0, rnd_req());
    run_txn(2'd0, rnd_rsp(), 1'b1, '0);
    idle_watch(20, "stuck request not regranted");
    chk("stuck ack held", bus.dtm_req_ack[0], 1'b1);
    bus.dtm_req_req[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("ack cleared after drop", bus.dtm_req_ack[0], 1'b0);
    raise(2'd0, rnd_req());
    run_txn(2'd0, rnd_rsp(), 1'b0, '0);
    idle_watch(20, "re-raised request granted once");

    // Port 1 arrives while port 0 waits for its response.
    raise(2'd0, rnd_req());
    run_txn(2'd0, rnd_rsp(), 1'b0, 4'b0010);
    chk("idle gap before late grant", {busy, bus.dm_req_req, grant_id}, {1'b0, 1'b0, 2'd0});
    @(negedge clk);
    chk("late port granted next edge", {busy, bus.dm_req_req, grant_id}, {1'b1, 1'b1, 2'd1});
    run_txn(2'd1, rnd_rsp(), 1'b0, '0);

    // Reset while the response is being forwarded.
    raise(2'd2, rnd_req());
    req_phase(2'd2, 1'b0);
    rsp_phase(2'd2, rnd_rsp(), '0);
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset mid-transaction");
    rst = 1'b0;
    for (int p = 0; p < NP; p++) rsp_model[p] = '0;
    m_ptr = 0;
    raise(2'd1, rnd_req());
    run_txn(2'd1, rnd_rsp(), 1'b0, '0);

    // Random request sets, with occasional late arrivals, against the pointer model.
    for (int r = 0; r < 40; r++) begin
      pend = NP'($urandom_range(1, 15));
      for (int p = 0; p < NP; p++) if (pend[p[1:0]]) raise(p[1:0], rnd_req());
      while (pend != '0) begin
        g_m  = model_pick(pend);
        pend[g_m] = 1'b0;
        late = ($urandom_range(0, 2) == 0) ? (NP'($urandom()) & ~pend) : '0;
        late[g_m] = 1'b0;
        run_txn(g_m, rnd_rsp(), 1'b0, late);
        pend = pend | late;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter_rr.md
# dbus_arbiter_rr

Parametrised round-robin DBus arbiter connecting `NUM_PORTS` DTMs to one Debug Module.
- Every DBus signal uses a four-phase req/ack handshake.
- Each port's request is forwarded to the DM, and the DM's response is routed back to the port that issued the request.
- All asynchronous handshake inputs pass through `SYNC_STAGES` synchronizers, so DTMs and the DM may run on any clock.
- The block sits between the JTAG/alternate DTMs and the DM, and replaces the fixed two-port arbiter.

## Interface
- `NUM_PORTS`, 2: number of DTM ports; legal range 2..16.
- `DBUS_REQ_BITS`, 41: width of DBus request data.
- `DBUS_RSP_BITS`, 36: width of DBus response data.
- `SYNC_STAGES`, 2: synchronizer depth applied to every `*_req` and `*_ack` input; 2 or more.
- `PORT_W`, $clog2(NUM_PORTS): derived; width of the grant index.
- Clocking and reset (decided): one clock; reset is synchronous and active-high.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `dtm_req_req`  in  NUM_PORTS  per-port request strobe.
- `dtm_req_ack`  out  NUM_PORTS  per-port request acknowledge.
- `dtm_req_bits`  in  NUM_PORTS*DBUS_REQ_BITS  request data; port p occupies slice [p*DBUS_REQ_BITS +: DBUS_REQ_BITS].
- `dtm_rsp_req`  out  NUM_PORTS  per-port response strobe.
- `dtm_rsp_ack`  in  NUM_PORTS  per-port response acknowledge.
- `dtm_rsp_bits`  out  NUM_PORTS*DBUS_RSP_BITS  response data; sliced the same way as requests.
- `dm_req_req`  out  1  request strobe to the DM.
- `dm_req_ack`  in  1  DM request acknowledge.
- `dm_req_bits`  out  DBUS_REQ_BITS  latched request data.
- `dm_rsp_req`  in  1  DM response strobe.
- `dm_rsp_ack`  out  1  response acknowledge to the DM.
- `dm_rsp_bits`  in  DBUS_RSP_BITS  DM response data.
- `grant_id`  out  PORT_W  index of the port currently or last granted.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Synchronizers.** `req_s[p]` denotes the synchronized `dtm_req_req[p]`; the same convention applies to the other three async inputs.
- **Eligibility.** Port p is eligible when `req_s[p]=1` and `dtm_req_ack[p]=0`.
  - A request held high after its ack is therefore never re-accepted until the port drops it.
- **FSM states:**
  - IDLE: when any port is eligible, grant the first eligible port at or after `rr_ptr`, searching upward with wrap at NUM_PORTS-1→0.
    - In the same edge: latch that port's bits into `dm_req_bits`, set `grant_id`, set `dtm_req_ack[g]`, set `dm_req_req`, then → REQ.
  - REQ: when `dm_req_ack_s=1`, clear `dm_req_req` → REQ_REL.
  - REQ_REL: when `dm_req_ack_s=0` → RSP_WAIT.
  - RSP_WAIT: when `dm_rsp_req_s=1`, latch `dm_rsp_bits` into port g's output slice, set `dm_rsp_ack` → RSP_DM_REL.
  - RSP_DM_REL: when `dm_rsp_req_s=0`, clear `dm_rsp_ack`, set `dtm_rsp_req[g]` → RSP_FWD.
  - RSP_FWD: when `rsp_ack_s[g]=1`, clear `dtm_rsp_req[g]` → RSP_REL.
  - RSP_REL: when `rsp_ack_s[g]=0`, set `rr_ptr` = (g+1) mod NUM_PORTS → IDLE.
- **Request acknowledge.** `dtm_req_ack[p]` is managed independently of the FSM: it clears on the first edge where `req_s[p]=0`. This lets the DTM release its request while the transaction is still in flight.
- **Data stability.**
  - `dm_req_bits` changes only on a grant.
  - Each `dtm_rsp_bits` slice changes only on a response latch for that port.
  - Non-granted slices are held at their last value.
- **Single transaction in flight.** Requests arriving during a transaction wait, and are arbitrated on return to IDLE.
- **Reset** (any cycle, including mid-transaction):
  - FSM → IDLE, `rr_ptr` = 0.
  - All outputs 0: `dtm_req_ack`, `dtm_rsp_req`, `dtm_rsp_bits`, `dm_req_req`, `dm_req_bits`, `dm_rsp_ack`, `grant_id`, `busy`.
  - All synchronizer stages are cleared.
  - The partial transaction is abandoned, with no replay.

## Timing
- **Input to visibility.** An input change becomes visible as its `_s` value after SYNC_STAGES rising edges.
- **Request to DM.** `dm_req_req` rises 1 edge after `req_s` goes high while in IDLE, i.e. SYNC_STAGES+1 edges from the input change. `dtm_req_ack[g]` rises on the same edge.
- **Each FSM step.** Every transition consumes 1 edge after its `_s` condition is true. There is no timeout: each state waits indefinitely.
- **Minimum transaction length.** IDLE→IDLE takes 6 handshake edges plus synchronizer latency for each edge.
- **Back-to-back grant.** A new grant can occur on the edge after the cycle the FSM enters IDLE.
- **Simultaneous eligibility.** Round-robin order is strictly by `rr_ptr`; a port is never granted twice while another eligible port waits.

## Test plan
- **Single port round trip.** NUM_PORTS=2; port 1 sends 0x1_2345_6789A; DM acks and then returns 0x9_8765_4321 → `dm_req_bits`=0x1_2345_6789A, `grant_id`=1, `dtm_rsp_bits` slice 1=0x9_8765_4321, slice 0 stays 0, FSM ends in IDLE with `rr_ptr`=0.
- **Two ports, continuous requests.** Both ports hold requests continuously, toggling after each ack → grants alternate 0,1,0,1; `dm_req_req` rises SYNC_STAGES+1 edges after the first request.
- **Four ports with wrap.** NUM_PORTS=4; all ports request after a grant to port 3 → next grant is port 0, then 1, 2, 3.
- **Stuck-high request.** A DTM holds `dtm_req_req` high after its ack → no second grant to that port; after it drops and re-raises, it is granted exactly once.
- **Reset mid-transaction.** Assert `rst` for 1 cycle while in RSP_FWD → next cycle all outputs are 0, `busy`=0, `grant_id`=0; a fresh request then completes normally.
- **Late arrival during transaction.** Port 0 is in flight and port 1 requests during RSP_WAIT → port 1 is not granted until port 0 completes RSP_REL, then is granted on the following edge.
